// File: rtl/numa_arb_pkg.sv
// Shared types and helpers for the NUMA memory-port arbiter.
package numa_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;

   localparam logic [31:0] POISON_DEFAULT = 32'hDEADBEEF;
   localparam int unsigned MAX_CORES      = 8;
   localparam int unsigned BUS_W          = 32 * MAX_CORES;

   // Extract the 32-bit slice belonging to core idx from a zero-extended flat bus.
   function automatic logic [31:0] core_slice(input logic [BUS_W-1:0] bus, input int unsigned idx);
      return 32'(bus >> (32 * idx));
   endfunction

endpackage

// File: rtl/numa_rr_pick.sv
// Combinational round-robin picker: first requester above last, wrapping modulo NCORES.
module numa_rr_pick #(
   parameter int unsigned NCORES = 2,
   localparam int unsigned IW    = $clog2(NCORES)
) (
   input  logic [NCORES-1:0] req,
   input  logic [IW-1:0]     last,
   output logic              any,
   output logic [IW-1:0]     idx
);

   int unsigned cand;

   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = 0;
      for (int unsigned k = 1; k <= NCORES; k++) begin
         cand = (32'(last) + k) % NCORES;
         if (!any && req[IW'(cand)]) begin
            any = 1'b1;
            idx = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/numa_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NCORES cores, with a
// watchdog that completes stuck transactions with a poison value and sticky err.
module numa_mem_arbiter
   import numa_arb_pkg::*;
#(
   parameter int unsigned NCORES  = 2,
   parameter int unsigned TIMEOUT = 16,
   parameter logic [31:0] POISON  = POISON_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NCORES-1:0]      core_req,
   input  logic [32*NCORES-1:0]   core_adr,
   input  logic [32*NCORES-1:0]   core_wdata,
   input  logic [NCORES-1:0]      core_we,
   output logic [NCORES-1:0]      core_stall,
   output logic [31:0]            core_rdata,
   output logic                   mem_req,
   output logic [31:0]            mem_adr,
   output logic [31:0]            mem_wdata,
   output logic                   mem_we,
   input  logic [31:0]            mem_rdata,
   input  logic                   mem_ack,
   output logic                   err
);

   localparam int unsigned IW = $clog2(NCORES);
   localparam int unsigned WW = $clog2(TIMEOUT + 1);

   arb_state_e        state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     last_q, last_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              req_q, req_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [WW-1:0]     wdog_q, wdog_d;

   logic              pick_any;
   logic [IW-1:0]     pick_idx;
   logic [BUS_W-1:0]  adr_ext, wdata_ext;

   assign adr_ext   = BUS_W'(core_adr);
   assign wdata_ext = BUS_W'(core_wdata);

   numa_rr_pick #(.NCORES(NCORES)) u_pick (
      .req  (core_req),
      .last (last_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wdog_d  = wdog_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               adr_d   = core_slice(adr_ext, 32'(pick_idx));
               wdata_d = core_slice(wdata_ext, 32'(pick_idx));
               we_d    = |(core_we & (NCORES'(1) << pick_idx));
               req_d   = 1'b1;
               wdog_d  = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Ack is checked first so a coinciding timeout loses.
            if (mem_ack) begin
               if (!we_q) rdata_d = mem_rdata;
               req_d   = 1'b0;
               state_d = DONE;
            end else if (wdog_q == WW'(TIMEOUT - 1)) begin
               rdata_d = POISON;
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         DONE: begin
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(NCORES - 1);
         adr_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         wdog_q  <= wdog_d;
      end
   end

   assign core_stall = core_req & ~((state_q == DONE) ? (NCORES'(1) << grant_q) : '0);
   assign core_rdata = rdata_q;
   assign mem_req    = req_q;
   assign mem_adr    = adr_q;
   assign mem_wdata  = wdata_q;
   assign mem_we     = we_q;
   assign err        = err_q;

endmodule

// File: tb/tb_numa_mem_arbiter.sv
// Randomized self-checking bench for numa_mem_arbiter against a transaction-level model.
module tb_numa_mem_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned TO = 8;
   localparam int unsigned BW = 32 * N;

   logic            clk;
   logic            reset;
   logic [N-1:0]    core_req;
   logic [BW-1:0]   core_adr;
   logic [BW-1:0]   core_wdata;
   logic [N-1:0]    core_we;
   logic [N-1:0]    core_stall;
   logic [31:0]     core_rdata;
   logic            mem_req;
   logic [31:0]     mem_adr;
   logic [31:0]     mem_wdata;
   logic            mem_we;
   logic [31:0]     mem_rdata;
   logic            mem_ack;
   logic            err;

   numa_mem_arbiter #(
      .NCORES  (N),
      .TIMEOUT (TO),
      .POISON  (32'hDEADBEEF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .core_req   (core_req),
      .core_adr   (core_adr),
      .core_wdata (core_wdata),
      .core_we    (core_we),
      .core_stall (core_stall),
      .core_rdata (core_rdata),
      .mem_req    (mem_req),
      .mem_adr    (mem_adr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_tests;
   int unsigned n_fail;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned rr_pick(input logic [N-1:0] m, input int unsigned last);
      logic [N-1:0] t;
      for (int unsigned k = 1; k <= N; k++) begin
         int unsigned c;
         c = (last + k) % N;
         t = m >> c;
         if (t[0]) return c;
      end
      return 0;
   endfunction

   function automatic logic [BW-1:0] rand_bus();
      logic [BW-1:0] b;
      b = '0;
      for (int i = 0; i < int'(N); i++) b = (b << 32) | BW'($urandom());
      return b;
   endfunction

   // Reference model state
   int unsigned m_last;
   logic [31:0] m_rdata;
   logic        m_err;

   initial begin
      logic [N-1:0] mask, we_t;
      int unsigned  win, w;
      logic [31:0]  exp_adr, exp_wd, rd;
      logic         exp_we, do_rst, drop, fin, rst_hit;

      n_tests = 0;
      n_fail  = 0;
      reset = 1'b0; core_req = '0; core_adr = '0; core_wdata = '0; core_we = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      #1 reset = 1'b1;
      #2;
      check_eq("rst_mem_req",   32'(mem_req), 32'd0);
      check_eq("rst_mem_we",    32'(mem_we), 32'd0);
      check_eq("rst_mem_adr",   mem_adr, 32'd0);
      check_eq("rst_mem_wdata", mem_wdata, 32'd0);
      check_eq("rst_rdata",     core_rdata, 32'd0);
      check_eq("rst_err",       32'(err), 32'd0);
      check_eq("rst_stall",     32'(core_stall), 32'd0);
      next_cycle();
      reset = 1'b0;
      m_last = N - 1; m_rdata = '0; m_err = 1'b0;

      for (int unsigned r = 0; r < 400; r++) begin
         // IDLE cycle: present requests; early rounds are full contention with instant acks
         mask = (r < 6) ? '1 : N'($urandom_range(0, (1 << N) - 1));
         core_req = mask; core_adr = rand_bus(); core_wdata = rand_bus(); core_we = N'($urandom());
         mem_ack = 1'($urandom()); mem_rdata = $urandom();
         @(negedge clk);
         check_eq("idle_req",   32'(mem_req), 32'd0);
         check_eq("idle_stall", 32'(core_stall), 32'(mask));
         check_eq("idle_err",   32'(err), 32'(m_err));
         if (mask == '0) begin
            next_cycle();
            continue;
         end
         win     = rr_pick(mask, m_last);
         exp_adr = 32'(core_adr >> (32 * win));
         exp_wd  = 32'(core_wdata >> (32 * win));
         we_t    = core_we >> win;
         exp_we  = we_t[0];
         do_rst  = (r % 37 == 20);
         drop    = ($urandom_range(0, 3) == 0);
         if (r < 6)                          w = 0;
         else if (do_rst)                    w = TO + 2;
         else if ($urandom_range(0, 7) == 0) w = TO + 2;
         else                                w = $urandom_range(0, TO - 1);
         rst_hit = 1'b0;
         next_cycle();

         for (int unsigned k = 0; k < TO; k++) begin
            core_adr = rand_bus(); core_wdata = rand_bus(); core_we = N'($urandom());
            if (k == 1 && drop) mask = mask & ~(N'(1) << win);
            core_req  = mask;
            mem_ack   = (k == w);
            rd        = $urandom();
            mem_rdata = rd;
            @(negedge clk);
            check_eq("busy_req",   32'(mem_req), 32'd1);
            check_eq("busy_adr",   mem_adr, exp_adr);
            check_eq("busy_wdata", mem_wdata, exp_wd);
            check_eq("busy_we",    32'(mem_we), 32'(exp_we));
            check_eq("busy_stall", 32'(core_stall), 32'(mask));
            check_eq("busy_rdata", core_rdata, m_rdata);
            if (do_rst && k == 1) begin
               reset = 1'b1;
               #1;
               check_eq("abort_req",   32'(mem_req), 32'd0);
               check_eq("abort_err",   32'(err), 32'd0);
               check_eq("abort_rdata", core_rdata, 32'd0);
               next_cycle();
               reset = 1'b0;
               m_last = N - 1; m_rdata = '0; m_err = 1'b0;
               rst_hit = 1'b1;
               break;
            end
            fin = 1'b0;
            if (k == w) begin
               if (!exp_we) m_rdata = rd;
               fin = 1'b1;
            end else if (k == TO - 1) begin
               m_rdata = 32'hDEADBEEF;
               m_err   = 1'b1;
               fin     = 1'b1;
            end
            next_cycle();
            if (fin) break;
         end
         if (rst_hit) continue;

         // DONE cycle: winner released for one cycle; stray acks must be ignored
         mem_ack = 1'($urandom()); mem_rdata = $urandom();
         @(negedge clk);
         check_eq("done_req",   32'(mem_req), 32'd0);
         check_eq("done_stall", 32'(core_stall), 32'(mask & ~(N'(1) << win)));
         check_eq("done_rdata", core_rdata, m_rdata);
         check_eq("done_err",   32'(err), 32'(m_err));
         m_last = win;
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/numa_mem_arbiter.md
Name: numa_mem_arbiter

Overview:
- Shares one memory port between NCORES multicycle MIPS cores in the NUMA system.
- Each core presents a memory request. The arbiter grants requests round-robin, forwards the winner's address and data to memory, and waits for the memory acknowledge.
- Every core that is waiting is held with its per-core stall line.
- A watchdog bounds how long a transaction may wait. A timed-out transaction completes with a poison value and sets a sticky error.

Parameters:
- NCORES, 2: number of requesting cores (2..8).
- TIMEOUT, 16: maximum BUSY cycles before the watchdog fires (at least 1).
- POISON, 32'hDEADBEEF: read data returned on timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  NCORES  per-core request valid; bit i belongs to core i.
- core_adr  in  32*NCORES  per-core byte address; slice i is bits [32i+31:32i].
- core_wdata  in  32*NCORES  per-core write data.
- core_we  in  NCORES  per-core write enable.
- core_stall  out  NCORES  per-core stall, connected to each mips stall input.
- core_rdata  out  32  registered read data, broadcast to all cores.
- mem_req  out  1  memory request valid.
- mem_adr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  memory read data; valid while mem_ack is high.
- mem_ack  in  1  memory completion, sampled while mem_req is high.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, last_grant=NCORES-1 so that core 0 has first priority.
  - mem_req=0, mem_we=0, mem_adr=0, mem_wdata=0.
  - core_rdata=0, err=0, watchdog counter=0.
- Reset during BUSY aborts the transaction. mem_req drops in the same cycle. The memory side must tolerate the abort.
- core_stall[i] = core_req[i] & ~(state==DONE & grant==i). This output is combinational, so a requesting core is stalled during the cycle of assertion.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If core_req is non-zero, pick the first requester searching upward from last_grant+1, wrapping modulo NCORES.
  - Register grant, adr, wdata and we from the winner. Set mem_req=1 and clear the watchdog. Go to BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - mem_req, mem_adr, mem_wdata and mem_we are held stable.
  - On mem_ack: if mem_we=0, capture mem_rdata into core_rdata; on a write, core_rdata holds its previous value. Drop mem_req and go to DONE.
  - If mem_ack is not seen and the counter reaches TIMEOUT-1: core_rdata=POISON, err=1, drop mem_req, go to DONE.
  - If mem_ack and the timeout coincide, the ack wins.
- DONE (one cycle):
  - core_stall[grant] is low and core_rdata is valid for the granted core.
  - Set last_grant=grant and go to IDLE. Other requests are picked in the IDLE cycle that follows.
- Latency: with an ack in the first BUSY cycle, a request raised in cycle 0 sees mem_req in cycle 1 and stall low in cycle 2, i.e. 2 stall cycles minimum. Each wait-state cycle adds one.
- If the requester drops core_req during BUSY, the transaction still completes (a write is still performed). DONE then has no visible effect and last_grant still updates.
- mem_ack outside BUSY is ignored.
- Fairness: with all cores requesting continuously, grants rotate 0,1,..,NCORES-1,0. No core waits more than NCORES transactions.
- err is cleared only by reset.

Decomposition:
- Package numa_arb_pkg holds:
  - the state enum typedef (IDLE, BUSY, DONE);
  - the POISON default constant;
  - a function that slices the flattened core buses.
- Sub-module numa_rr_pick: a combinational round-robin picker.
  - Inputs: req[NCORES], last[$clog2(NCORES)].
  - Outputs: any, idx.
- All state and registers live in the top module.

Test Plan:
- Single read, NCORES=2: core_req=01, core_adr[0]=0x40; memory acks in the first BUSY cycle with 0x1234 -> mem_req=1 with mem_adr=0x40 in cycle 1; stall[0] high in cycles 0-1 and low in cycle 2; core_rdata=0x1234 in cycle 2.
- Contention after reset: core_req=11 held, acks immediate -> grant order 0,1,0,1 on mem_adr; each stall bit low once per 3-cycle round in alternation.
- Write with wait states: core 1 we=1, adr=0x80, wdata=0xAA; ack after 3 BUSY cycles -> mem_we=1, mem_adr=0x80 and mem_wdata=0xAA stable for 3 cycles; core_rdata unchanged; stall[1] low in the cycle after the ack.
- Timeout, TIMEOUT=8, never ack -> mem_req high for exactly 8 cycles; then err=1 and core_rdata=0xDEADBEEF with stall low for one cycle; err stays 1 through later good transactions.
- Reset during BUSY -> mem_req and err drop in the same cycle; after release, core 0 wins a simultaneous 11 request.
- Core 0 drops core_req in the second BUSY cycle of a write -> write is still issued until ack; no stall glitch on core 1; core 1 is granted next.
